digit_split_seq: RTL and testbench

DIGIT_SPLIT_SEQ -- requirements
Module: digit_split_seq

---
 rtl/digit_split_seq_if.sv | 22 ++
 rtl/digit_split_seq.sv | 145 ++++++++++++++
 tb/tb_digit_split_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/digit_split_seq_if.sv
// Handshake and result bundle for digit_split_seq.
// master: requester driving start/value; slave: the converter.
interface digit_split_seq_if;
  logic       start;
  logic [7:0] value;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] units;
  logic       err;

  modport master (
    output start, value,
    input  busy, done, hundreds, tens, units, err
  );

  modport slave (
    input  start, value,
    output busy, done, hundreds, tens, units, err
  );
endinterface

// File: rtl/digit_split_seq.sv
// digit_split_seq: splits an 8-bit unsigned value into decimal digits by
// repeated subtraction.
// Optional macro DIGIT_SPLIT_HUNDREDS_EN: adds the SUB_H stage so the full
// 0-255 range converts. Without it, values above 99 are flagged with err and
// tens/units forced to 4'hF, and hundreds is tied to 0.
module digit_split_seq (
  input  logic              clk,
  input  logic              rst_n,
  digit_split_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef DIGIT_SPLIT_HUNDREDS_EN
    SUB_H = 2'd1,
`endif
    SUB_T = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [7:0] rem;
  logic [3:0] tcnt;
  logic [3:0] tens_q;
  logic [3:0] units_q;
  logic       err_q;
`ifdef DIGIT_SPLIT_HUNDREDS_EN
  logic [3:0] hcnt;
  logic [3:0] hund_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef DIGIT_SPLIT_HUNDREDS_EN
          state_nx = SUB_H;
`else
          state_nx = SUB_T;
`endif
        end
      end
`ifdef DIGIT_SPLIT_HUNDREDS_EN
      SUB_H: if (rem < 8'd100) state_nx = SUB_T;
      SUB_T: if (rem < 8'd10) state_nx = FIN;
`else
      // Out-of-range values finish straight from the first SUB_T cycle.
      SUB_T: if ((rem < 8'd10) || (rem > 8'd99)) state_nx = FIN;
`endif
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
`ifdef DIGIT_SPLIT_HUNDREDS_EN
      SUB_H:   bus.busy = 1'b1;
`endif
      SUB_T:   bus.busy = 1'b1;
      FIN:     bus.done = 1'b1;
      default: ;
    endcase
  end

  // Remainder, digit counters and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      tcnt    <= '0;
      tens_q  <= '0;
      units_q <= '0;
      err_q   <= 1'b0;
`ifdef DIGIT_SPLIT_HUNDREDS_EN
      hcnt    <= '0;
      hund_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem     <= bus.value;
            tcnt    <= '0;
            tens_q  <= '0;
            units_q <= '0;
            err_q   <= 1'b0;
`ifdef DIGIT_SPLIT_HUNDREDS_EN
            hcnt    <= '0;
            hund_q  <= '0;
`endif
          end
        end
`ifdef DIGIT_SPLIT_HUNDREDS_EN
        SUB_H: begin
          if (rem >= 8'd100) begin
            rem  <= rem - 8'd100;
            hcnt <= hcnt + 4'd1;
          end
        end
`endif
        SUB_T: begin
`ifndef DIGIT_SPLIT_HUNDREDS_EN
          if (rem > 8'd99) begin
            err_q   <= 1'b1;
            tens_q  <= '1;
            units_q <= '1;
          end else
`endif
          if (rem >= 8'd10) begin
            rem  <= rem - 8'd10;
            tcnt <= tcnt + 4'd1;
          end else begin
            tens_q  <= tcnt;
            units_q <= rem[3:0];
`ifdef DIGIT_SPLIT_HUNDREDS_EN
            hund_q  <= hcnt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tens  = tens_q;
  assign bus.units = units_q;
  assign bus.err   = err_q;
`ifdef DIGIT_SPLIT_HUNDREDS_EN
  assign bus.hundreds = hund_q;
`else
  assign bus.hundreds = '0;
`endif

endmodule

// File: tb/tb_digit_split_seq.sv
// Bench for digit_split_seq: a decimal-arithmetic model checked every cycle,
// plus directed conversions with literal latency and digit expectations.
module tb_digit_split_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  digit_split_seq_if bus ();

  digit_split_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {err, hundreds, tens, units} from plain decimal arithmetic.
  function automatic logic [12:0] exp_result(input logic [7:0] v);
    int unsigned n;
    n = v;
`ifdef DIGIT_SPLIT_HUNDREDS_EN
    return {1'b0, 4'(n / 100), 4'((n % 100) / 10), 4'(n % 10)};
`else
    if (n > 99) return {1'b0, 4'd0, 4'hF, 4'hF} | 13'h1000;
    return {1'b0, 4'd0, 4'(n / 10), 4'(n % 10)};
`endif
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int unsigned exp_lat(input logic [7:0] v);
    int unsigned n;
    n = v;
`ifdef DIGIT_SPLIT_HUNDREDS_EN
    return n / 100 + (n % 100) / 10 + 2;
`else
    if (n > 99) return 1;
    return n / 10 + 1;
`endif
  endfunction

  // Model: countdown to done, results held between conversions.
  int unsigned m_cnt = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [12:0] m_res = '0;
  logic [12:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
        m_res  <= m_pend;
      end
      m_cnt <= m_cnt - 1;
    end else if (bus.start) begin
      m_pend <= exp_result(bus.value);
      m_cnt  <= exp_lat(bus.value);
      m_busy <= 1'b1;
      m_res  <= '0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
      chk("err", int'(bus.err), int'(m_res[12]));
      chk("hundreds", int'(bus.hundreds), int'(m_res[11:8]));
      chk("tens", int'(bus.tens), int'(m_res[7:4]));
      chk("units", int'(bus.units), int'(m_res[3:0]));
    end
  end

  // One conversion; optional extra start pulse after edge pulse_at.
  task automatic run(input logic [7:0] v, input int lat, input int h,
                     input int t, input int u, input int e, input int pulse_at);
    int got;
    got = 0;
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.value = 8'($urandom);
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        got = n;
        break;
      end
      #1;
      bus.start = (n == pulse_at);
      bus.value = 8'($urandom);
    end
    bus.start = 1'b0;
    if (got == 0) chk("done_timeout", 0, 1);
    else begin
      chk("latency", got, lat);
      chk("lit_hundreds", int'(bus.hundreds), h);
      chk("lit_tens", int'(bus.tens), t);
      chk("lit_units", int'(bus.units), u);
      chk("lit_err", int'(bus.err), e);
      @(posedge clk); #1;
      chk("done_pulse_len", int'(bus.done), 0);
      chk("hold_tens", int'(bus.tens), t);
      chk("hold_units", int'(bus.units), u);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    bus.start = 1'b0;
    bus.value = '0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #2;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_tens", int'(bus.tens), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

`ifdef DIGIT_SPLIT_HUNDREDS_EN
    run(8'd255, 9, 2, 5, 5, 0, 0);
    run(8'd47, 6, 0, 4, 7, 0, 0);
    run(8'd0, 2, 0, 0, 0, 0, 0);
    run(8'd99, 11, 0, 9, 9, 0, 0);
    run(8'd100, 3, 1, 0, 0, 0, 0);
    run(8'd150, 8, 1, 5, 0, 0, 0);
    run(8'd12, 3, 0, 1, 2, 0, 0);
    run(8'd47, 6, 0, 4, 7, 0, 2);
`else
    run(8'd47, 5, 0, 4, 7, 0, 0);
    run(8'd0, 1, 0, 0, 0, 0, 0);
    run(8'd99, 10, 0, 9, 9, 0, 0);
    run(8'd100, 1, 0, 15, 15, 1, 0);
    run(8'd150, 1, 0, 15, 15, 1, 0);
    run(8'd12, 2, 0, 1, 2, 0, 0);
    run(8'd255, 1, 0, 15, 15, 1, 0);
    run(8'd47, 5, 0, 4, 7, 0, 2);
`endif

    // Abort a conversion of 99 with reset after E3.
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.value = 8'd99;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_tens", int'(bus.tens), 0);
    chk("abort_units", int'(bus.units), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    chk("abort_no_done", int'(seen_done), 0);
`ifdef DIGIT_SPLIT_HUNDREDS_EN
    run(8'd99, 11, 0, 9, 9, 0, 0);
`else
    run(8'd99, 10, 0, 9, 9, 0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
